// File: rtl/cd_dsp_pkg.sv
// -----------------------------------------------------------------------------
// cd_dsp_pkg
// Shared types and constants for the SPI frame deframer slice.
//   deframer_state_t : frame FSM states (HUNT, DATA, CHECK)
//   fifo_entry_t     : one output FIFO entry {sof, data}
//   DEFAULT_SYNC_WORD: default 16-bit frame sync pattern (MSB-first)
//   shift_in()       : MSB-first serial shift helper
// -----------------------------------------------------------------------------
package cd_dsp_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } deframer_state_t;

  typedef struct packed {
    logic       sof;
    logic [7:0] data;
  } fifo_entry_t;

  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA55A;

  // Oldest bit leaves at the top, the new bit enters at the bottom.
  function automatic logic [15:0] shift_in(input logic [15:0] sr, input logic b);
    return {sr[14:0], b};
  endfunction

endpackage

// File: rtl/spi_frame_deframer_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Show-ahead synchronous FIFO of fifo_entry_t with registered head/valid and a
// sticky drop-on-full overflow flag.
//   clk, rst      : clock, asynchronous active-high reset
//   push, wr_entry: write request and entry
//   pop           : consume head (ignored while valid is low)
//   head, valid   : registered head entry and not-empty flag
//   overflow      : sticky, set when a push is dropped on a full FIFO
// -----------------------------------------------------------------------------
module byte_fifo
  import cd_dsp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t wr_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        valid,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  fifo_entry_t     mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [AW:0]     count_r, count_nxt_s;
  fifo_entry_t     head_r, head_nxt_s;
  logic            valid_r, overflow_r;
  logic            full_s, do_push_s, do_pop_s, drop_s;

  // Next pointers, count and head; a pop on full frees the slot the push uses.
  always_comb begin
    do_pop_s     = pop & valid_r;
    full_s       = (count_r == DEPTH_C);
    do_push_s    = push & (~full_s | do_pop_s);
    drop_s       = push & full_s & ~do_pop_s;
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = head_r;
    if (do_pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (do_push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    // The write bypasses straight to the head when it lands in the head slot.
    if (do_push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = wr_entry;
    end else if (count_nxt_s != {(AW+1){1'b0}}) begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Control state: pointers, count, head, valid and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      head_r     <= '0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      rd_ptr_r   <= rd_ptr_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      count_r    <= count_nxt_s;
      head_r     <= head_nxt_s;
      valid_r    <= (count_nxt_s != {(AW+1){1'b0}});
      overflow_r <= overflow_r | drop_s;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_entry;
    end
  end

  assign head     = head_r;
  assign valid    = valid_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/spi_frame_deframer.sv
// -----------------------------------------------------------------------------
// spi_frame_deframer
// Samples MOSI on synchronized SCKin falling edges, hunts for SYNC_WORD, then
// cuts fixed-length frames into MSB-first bytes delivered through a FIFO.
// Optional build macro: FRAME_CHECKSUM_EN (last byte of a frame is the XOR of
// the preceding bytes; mismatch pulses frame_err).
//   CLK, RST     : clock, asynchronous active-high reset
//   SCKin, MOSI  : raw bit clock (async) and data bit
//   byte_data/byte_sof/byte_valid/byte_ready : output byte stream handshake
//   locked       : frame lock held
//   overflow     : sticky, byte dropped on full FIFO
//   frame_err    : one-cycle checksum mismatch pulse (0 without the macro)
// -----------------------------------------------------------------------------
module spi_frame_deframer
  import cd_dsp_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
  parameter int          FRAME_BYTES = 4,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          MISS_LIMIT  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCKin,
  input  logic       MOSI,
  output logic [7:0] byte_data,
  output logic       byte_sof,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       locked,
  output logic       overflow,
  output logic       frame_err
);

  localparam logic [7:0] FRAME_BYTES_C = FRAME_BYTES[7:0];
  localparam logic [7:0] MISS_LIMIT_C  = MISS_LIMIT[7:0];

  logic            sck_meta_r, sck_sync_r, sck_prev_r, fall_s;
  logic [15:0]     shift_r, shift_nxt_s;
  deframer_state_t state_r, state_nxt_s;
  logic [2:0]      bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]      byte_cnt_r, byte_cnt_nxt_s;
  logic [15:0]     chk_cnt_r, chk_cnt_nxt_s;
  logic [7:0]      miss_cnt_r, miss_cnt_nxt_s, miss_inc_s;
  logic            sof_pending_r, sof_pending_nxt_s;
  logic            locked_r, locked_nxt_s;
  logic            push_r, push_nxt_s;
  fifo_entry_t     push_entry_r, push_entry_nxt_s;
  logic            last_byte_s;
  fifo_entry_t     head_s;

  // SCKin synchronizer plus previous-sample register for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sck_meta_r <= 1'b0;
      sck_sync_r <= 1'b0;
      sck_prev_r <= 1'b0;
    end else begin
      sck_meta_r <= SCKin;
      sck_sync_r <= sck_meta_r;
      sck_prev_r <= sck_sync_r;
    end
  end

  assign fall_s      = sck_prev_r & ~sck_sync_r;
  assign shift_nxt_s = shift_in(shift_r, MOSI);
  assign miss_inc_s  = miss_cnt_r + 8'd1;
  assign last_byte_s = ((byte_cnt_r + 8'd1) == FRAME_BYTES_C);

  // Frame FSM next-state and counter logic; everything advances on samples.
  always_comb begin
    state_nxt_s       = state_r;
    bit_cnt_nxt_s     = bit_cnt_r;
    byte_cnt_nxt_s    = byte_cnt_r;
    chk_cnt_nxt_s     = chk_cnt_r;
    miss_cnt_nxt_s    = miss_cnt_r;
    sof_pending_nxt_s = sof_pending_r;
    locked_nxt_s      = locked_r;
    push_nxt_s        = 1'b0;
    push_entry_nxt_s  = push_entry_r;
    if (fall_s) begin
      case (state_r)
        HUNT: begin
          if (shift_nxt_s == SYNC_WORD) begin
            state_nxt_s       = DATA;
            bit_cnt_nxt_s     = 3'd0;
            byte_cnt_nxt_s    = 8'd0;
            miss_cnt_nxt_s    = 8'd0;
            sof_pending_nxt_s = 1'b1;
            locked_nxt_s      = 1'b1;
          end else begin
            state_nxt_s = HUNT;
          end
        end
        DATA: begin
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            push_nxt_s        = 1'b1;
            push_entry_nxt_s  = '{sof: sof_pending_r, data: shift_nxt_s[7:0]};
            sof_pending_nxt_s = 1'b0;
            byte_cnt_nxt_s    = byte_cnt_r + 8'd1;
            if (last_byte_s) begin
              state_nxt_s   = CHECK;
              chk_cnt_nxt_s = 16'd0;
            end else begin
              state_nxt_s = DATA;
            end
          end else begin
            state_nxt_s = DATA;
          end
        end
        CHECK: begin
          chk_cnt_nxt_s = chk_cnt_r + 16'd1;
          if (chk_cnt_r == 16'd15) begin
            bit_cnt_nxt_s  = 3'd0;
            byte_cnt_nxt_s = 8'd0;
            chk_cnt_nxt_s  = 16'd0;
            if (shift_nxt_s == SYNC_WORD) begin
              miss_cnt_nxt_s    = 8'd0;
              sof_pending_nxt_s = 1'b1;
              state_nxt_s       = DATA;
            end else if (miss_inc_s == MISS_LIMIT_C) begin
              miss_cnt_nxt_s = 8'd0;
              locked_nxt_s   = 1'b0;
              state_nxt_s    = HUNT;
            end else begin
              // Flywheel: trust frame timing through an isolated bad sync.
              miss_cnt_nxt_s    = miss_inc_s;
              sof_pending_nxt_s = 1'b1;
              state_nxt_s       = DATA;
            end
          end else begin
            state_nxt_s = CHECK;
          end
        end
        default: begin
          state_nxt_s  = HUNT;
          locked_nxt_s = 1'b0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Frame FSM state, counters and the registered FIFO write request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_r       <= 16'd0;
      state_r       <= HUNT;
      bit_cnt_r     <= 3'd0;
      byte_cnt_r    <= 8'd0;
      chk_cnt_r     <= 16'd0;
      miss_cnt_r    <= 8'd0;
      sof_pending_r <= 1'b0;
      locked_r      <= 1'b0;
      push_r        <= 1'b0;
      push_entry_r  <= '0;
    end else begin
      if (fall_s) begin
        shift_r <= shift_nxt_s;
      end
      state_r       <= state_nxt_s;
      bit_cnt_r     <= bit_cnt_nxt_s;
      byte_cnt_r    <= byte_cnt_nxt_s;
      chk_cnt_r     <= chk_cnt_nxt_s;
      miss_cnt_r    <= miss_cnt_nxt_s;
      sof_pending_r <= sof_pending_nxt_s;
      locked_r      <= locked_nxt_s;
      push_r        <= push_nxt_s;
      push_entry_r  <= push_entry_nxt_s;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] acc_r, acc_nxt_s;
  logic       frame_err_r, frame_err_nxt_s;

  // XOR accumulator over a frame's payload; checked when the last byte lands.
  always_comb begin
    acc_nxt_s       = acc_r;
    frame_err_nxt_s = 1'b0;
    if (fall_s && (state_r == DATA) && (bit_cnt_r == 3'd7)) begin
      if (last_byte_s) begin
        frame_err_nxt_s = (acc_r != shift_nxt_s[7:0]);
        acc_nxt_s       = 8'd0;
      end else begin
        acc_nxt_s = acc_r ^ shift_nxt_s[7:0];
      end
    end else if (fall_s && (state_r != DATA)) begin
      // Any sample outside the payload means the next byte starts a frame.
      acc_nxt_s = 8'd0;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Checksum accumulator and error pulse registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_r       <= 8'd0;
      frame_err_r <= 1'b0;
    end else begin
      acc_r       <= acc_nxt_s;
      frame_err_r <= frame_err_nxt_s;
    end
  end

  assign frame_err = frame_err_r;
`else
  assign frame_err = 1'b0;
`endif

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (push_r),
    .wr_entry (push_entry_r),
    .pop      (byte_ready),
    .head     (head_s),
    .valid    (byte_valid),
    .overflow (overflow)
  );

  assign byte_data = head_s.data;
  assign byte_sof  = head_s.sof;
  assign locked    = locked_r;

endmodule

// File: tb/tb_spi_frame_deframer.sv
module tb_spi_frame_deframer;

  localparam logic [15:0] SYNC = 16'hA55A;
  localparam int FB    = 4;
  localparam int DEPTH = 8;
  localparam int ML    = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SCKin = 1'b0;
  logic       MOSI = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_data;
  logic       byte_sof, byte_valid, locked, overflow, frame_err;

  int errors = 0;
  int checks = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  bit         lock_trace[$];
  bit         stim_q[$];
  int         exp_fe;
  bit         valid_seen;
  int         fe_pulses, fe_width_max, fe_cur, fe_total;

  spi_frame_deframer #(
    .SYNC_WORD   (SYNC),
    .FRAME_BYTES (FB),
    .FIFO_DEPTH  (DEPTH),
    .MISS_LIMIT  (ML)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SCKin      (SCKin),
    .MOSI       (MOSI),
    .byte_data  (byte_data),
    .byte_sof   (byte_sof),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .locked     (locked),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 CLK = ~CLK;

  // Output monitor: records popped bytes and frame_err pulse shapes.
  always @(negedge CLK) begin
    if (RST) begin
      fe_cur = 0;
    end else begin
      if (byte_valid) valid_seen = 1'b1;
      if (byte_valid && byte_ready) got_q.push_back({byte_sof, byte_data});
      if (frame_err) begin
        fe_cur++;
        fe_total++;
      end else if (fe_cur > 0) begin
        fe_pulses++;
        if (fe_cur > fe_width_max) fe_width_max = fe_cur;
        fe_cur = 0;
      end
    end
  end

  // Reference: walk the bit stream in frame-period units from the stream rules.
  function automatic void model_run(input bit bits[$]);
    logic [15:0] win;
    logic [7:0]  fb[$];
    logic [7:0]  x;
    bit lk;
    bit sof;
    int pos;
    int miss;
    win = 16'd0; lk = 1'b0; sof = 1'b0; pos = 0; miss = 0;
    exp_q.delete(); lock_trace.delete(); exp_fe = 0;
    foreach (bits[i]) begin
      win = {win[14:0], bits[i]};
      if (!lk) begin
        if (win == SYNC) begin
          lk = 1'b1; pos = 0; miss = 0; sof = 1'b1; fb.delete();
        end
      end else begin
        if (pos < FB * 8) begin
          if (pos % 8 == 7) begin
            exp_q.push_back({sof, win[7:0]});
            sof = 1'b0;
            fb.push_back(win[7:0]);
            if (fb.size() == FB) begin
              x = 8'd0;
              for (int k = 0; k < FB - 1; k++) x = x ^ fb[k];
              if (x != fb[FB-1]) exp_fe++;
            end
          end
          pos++;
        end else if (pos == FB * 8 + 15) begin
          if (win == SYNC) miss = 0; else miss++;
          if (miss == ML) lk = 1'b0;
          sof = 1'b1; fb.delete(); pos = 0;
        end else begin
          pos++;
        end
      end
      lock_trace.push_back(lk);
    end
  endfunction

  task automatic send_bit(input bit b);
    @(negedge CLK);
    MOSI = b; SCKin = 1'b1;
    repeat (4) @(negedge CLK);
    SCKin = 1'b0;
    repeat (4) @(negedge CLK);
    stim_q.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic set_ready(input bit v);
    @(posedge CLK); #1 byte_ready = v;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; SCKin = 1'b0; MOSI = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    got_q.delete(); stim_q.delete();
    valid_seen = 1'b0; fe_pulses = 0; fe_width_max = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (byte_data !== 8'd0)  begin errors++; $display("FAIL reset_data got=%0h exp=0", byte_data); end
    checks++; if (byte_sof !== 1'b0)   begin errors++; $display("FAIL reset_sof got=%0b exp=0", byte_sof); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", byte_valid); end
    checks++; if (locked !== 1'b0)     begin errors++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
  endtask

  task automatic test_basic_frame();
    logic [15:0] s;
    s = SYNC;
    do_reset();
    set_ready(1'b1);
    for (int i = 15; i >= 1; i--) send_bit(s[i]);
    model_run(stim_q);
    checks++; if (locked !== lock_trace[lock_trace.size()-1])
      begin errors++; $display("FAIL lock_bit15 got=%0b exp=%0b", locked, lock_trace[lock_trace.size()-1]); end
    send_bit(s[0]);
    model_run(stim_q);
    checks++; if (locked !== lock_trace[lock_trace.size()-1])
      begin errors++; $display("FAIL lock_bit16 got=%0b exp=%0b", locked, lock_trace[lock_trace.size()-1]); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_word(SYNC);
    repeat (6) @(negedge CLK);
    model_run(stim_q);
    checks++; if (got_q.size() !== exp_q.size())
      begin errors++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_byte%0d got=%0h exp=%0h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_locked_end got=%0b exp=1", locked); end
  endtask

  task automatic test_random_no_sync();
    logic [15:0] w;
    bit b;
    do_reset();
    set_ready(1'b1);
    w = 16'd0;
    for (int i = 0; i < 200; i++) begin
      b = bit'($urandom_range(0, 1));
      if ({w[14:0], b} == SYNC) b = ~b;
      w = {w[14:0], b};
      send_bit(b);
    end
    repeat (4) @(negedge CLK);
    model_run(stim_q);
    checks++; if (locked !== lock_trace[lock_trace.size()-1])
      begin errors++; $display("FAIL nosync_locked got=%0b exp=%0b", locked, lock_trace[lock_trace.size()-1]); end
    checks++; if (valid_seen !== (exp_q.size() != 0))
      begin errors++; $display("FAIL nosync_valid_seen got=%0b exp=%0b", valid_seen, exp_q.size() != 0); end
  endtask

  task automatic test_miss_flywheel();
    do_reset();
    set_ready(1'b1);
    send_word(SYNC);
    for (int i = 0; i < FB; i++) send_byte(8'($urandom));
    send_word(SYNC);
    for (int i = 0; i < FB; i++) send_byte(8'($urandom));
    send_word(16'hA55B);
    model_run(stim_q);
    checks++; if (locked !== 1'b1 || lock_trace[lock_trace.size()-1] !== 1'b1)
      begin errors++; $display("FAIL miss1_locked got=%0b exp=1", locked); end
    for (int i = 0; i < FB; i++) send_byte(8'($urandom));
    send_word(16'hA55B);
    model_run(stim_q);
    checks++; if (locked !== 1'b0 || lock_trace[lock_trace.size()-1] !== 1'b0)
      begin errors++; $display("FAIL miss2_locked got=%0b exp=0", locked); end
    // Back in HUNT: a frame without a leading sync must not produce bytes.
    send_byte(8'h3C); send_byte(8'hC3); send_byte(8'h0F); send_byte(8'hF0);
    repeat (6) @(negedge CLK);
    model_run(stim_q);
    checks++; if (got_q.size() !== exp_q.size() || exp_q.size() !== 3 * FB)
      begin errors++; $display("FAIL miss_count got=%0d exp=%0d", got_q.size(), 3 * FB); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL miss_byte%0d got=%0h exp=%0h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    set_ready(1'b0);
    send_word(SYNC);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FB; i++) send_byte(8'($urandom));
      if (f == 1) begin
        repeat (3) @(negedge CLK);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got=%0b exp=0", overflow); end
      end
      if (f < 2) send_word(SYNC);
    end
    repeat (4) @(negedge CLK);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
    checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%0b exp=1", byte_valid); end
    model_run(stim_q);
    set_ready(1'b1);
    repeat (DEPTH + 6) @(negedge CLK);
    checks++; if (got_q.size() !== DEPTH)
      begin errors++; $display("FAIL ovf_drain_count got=%0d exp=%0d", got_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_byte%0d got=%0h exp=%0h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] v;
    do_reset();
    set_ready(1'b1);
    send_word(SYNC);
    v = 8'hB6;
    for (int i = 7; i >= 3; i--) send_bit(v[i]);
    do_reset();
    checks++; if (locked !== 1'b0)     begin errors++; $display("FAIL rst_mid_locked got=%0b exp=0", locked); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%0b exp=0", byte_valid); end
    checks++; if (byte_data !== 8'd0)  begin errors++; $display("FAIL rst_mid_data got=%0h exp=0", byte_data); end
    set_ready(1'b1);
    for (int i = 2; i >= 0; i--) send_bit(v[i]);
    send_byte(8'h5A); send_byte(8'h12);
    checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_byte got=%0b exp=0", valid_seen); end
    send_word(SYNC);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    repeat (6) @(negedge CLK);
    model_run(stim_q);
    checks++; if (got_q.size() !== exp_q.size())
      begin errors++; $display("FAIL rst_mid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_mid_byte%0d got=%0h exp=%0h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      end
    end
  endtask

`ifdef FRAME_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    set_ready(1'b1);
    send_word(SYNC);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h07);
    send_word(SYNC);
    repeat (4) @(negedge CLK);
    model_run(stim_q);
    checks++; if (fe_pulses !== exp_fe)
      begin errors++; $display("FAIL csum_good got=%0d exp=%0d", fe_pulses, exp_fe); end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h06);
    send_word(SYNC);
    repeat (4) @(negedge CLK);
    model_run(stim_q);
    checks++; if (fe_pulses !== exp_fe || exp_fe !== 1)
      begin errors++; $display("FAIL csum_bad_pulses got=%0d exp=1", fe_pulses); end
    checks++; if (fe_width_max !== 1)
      begin errors++; $display("FAIL csum_width got=%0d exp=1", fe_width_max); end
    checks++; if (got_q.size() !== 2 * FB || got_q[got_q.size()-1] !== exp_q[exp_q.size()-1])
      begin errors++; $display("FAIL csum_last_pushed got=%0d bytes exp=%0d", got_q.size(), 2 * FB); end
  endtask
`endif

  initial begin
    fe_total = 0;
    test_reset();
    test_basic_frame();
    test_random_no_sync();
    test_miss_flywheel();
    test_overflow();
    test_reset_midbyte();
`ifdef FRAME_CHECKSUM_EN
    test_checksum();
`else
    checks++; if (fe_total !== 0) begin errors++; $display("FAIL frame_err_tied got=%0d exp=0", fe_total); end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
